// File: rtl/lane_scatter8.sv
// lane_scatter8: serial-to-parallel loader for the 8-lane reduction datapath.
// Words arrive one per cycle and fill lanes a..h in order; a completed (or
// flushed) group is held on the outputs until the downstream consumes it.
// Unfilled lanes on flush are padded with PAD (all-ones keeps an AND neutral).
module lane_scatter8 #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     PAD   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] lane_q [8];
  logic [WIDTH-1:0] lane_d [8];
  logic             accept;
  int unsigned      idx_i;

  // Next-state: fill lanes in order, close on 8th word or flush, hold until consumed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    lane_d  = lane_q;
    accept  = 1'b0;
    idx_i   = 32'(idx_q);

    unique case (state_q)
      FILL: begin
        accept = in_valid & in_ready_q;
        if (accept) begin
          lane_d[idx_q] = in_data;
          idx_d         = idx_q + 3'd1;
          count_d       = count_q + 4'd1;
          if (idx_q == 3'd7) begin
            state_d = HOLD;
          end else if (flush) begin
            // The word accepted this cycle is kept; only lanes after it are padded.
            for (int unsigned i = 0; i < 8; i++) begin
              if (i > idx_i) lane_d[i] = PAD;
            end
            state_d = HOLD;
          end
        end else if (flush && (idx_q != 3'd0)) begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (i >= idx_i) lane_d[i] = PAD;
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          idx_d   = 3'd0;
          count_d = 4'd0;
        end
      end
      default: state_d = FILL;
    endcase

    // Handshake flags are registered from the next state so they never glitch.
    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == HOLD);
  end

  // State, lane and handshake registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      lane_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      lane_q      <= lane_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign a = lane_q[0];
  assign b = lane_q[1];
  assign c = lane_q[2];
  assign d = lane_q[3];
  assign e = lane_q[4];
  assign f = lane_q[5];
  assign g = lane_q[6];
  assign h = lane_q[7];

endmodule

// File: tb/tb_lane_scatter8.sv
// Testbench for lane_scatter8: directed scenarios plus random traffic, checked
// against a group-level reference model (list of accepted words per group).
module tb_lane_scatter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] a, b, c, d, e, f, g, h;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;

  lane_scatter8 #(.WIDTH(8), .PAD(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] l [8];
    int         cnt;
  } grp_t;

  int         checks = 0;
  int         errors = 0;
  grp_t       sb_q[$];
  grp_t       held;
  logic [7:0] words[$];
  bit         m_hold;
  bit         m_rdy;
  logic [7:0] dut_l [8];

  assign dut_l[0] = a;
  assign dut_l[1] = b;
  assign dut_l[2] = c;
  assign dut_l[3] = d;
  assign dut_l[4] = e;
  assign dut_l[5] = f;
  assign dut_l[6] = g;
  assign dut_l[7] = h;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_group(input string tag, input grp_t x);
    for (int i = 0; i < 8; i++) chk($sformatf("%s lane%0d", tag, i), 32'(dut_l[i]), 32'(x.l[i]));
    chk($sformatf("%s count", tag), 32'(count), 32'(x.cnt));
  endfunction

  // Reference: a group is the list of accepted words; it closes at 8 words or
  // on flush with at least one word; missing lanes read as pad 0xFF.
  function automatic void model_step(input bit iv, input logic [7:0] dv, input bit fl, input bit ordy);
    grp_t gg;
    if (!m_hold) begin
      if (iv && m_rdy) words.push_back(dv);
      if (words.size() == 8 || (fl && words.size() > 0)) begin
        for (int i = 0; i < 8; i++) gg.l[i] = (i < words.size()) ? words[i] : 8'hFF;
        gg.cnt = words.size();
        sb_q.push_back(gg);
        held = gg;
        words.delete();
        m_hold = 1'b1;
        m_rdy  = 1'b0;
      end else begin
        m_rdy = 1'b1;
      end
    end else if (ordy) begin
      m_hold = 1'b0;
      m_rdy  = 1'b1;
    end
  endfunction

  // Called at posedge+1: check visible state, drive inputs for the next edge.
  task automatic cycle(input bit iv, input logic [7:0] dv, input bit fl, input bit ordy);
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    if (m_hold) check_group("hold", held);
    else chk("fill count", 32'(count), 32'(words.size()));
    in_valid  = iv;
    in_data   = dv;
    flush     = fl;
    out_ready = ordy;
    model_step(iv, dv, fl, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("rst lane%0d", i), 32'(dut_l[i]), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    words.delete();
    sb_q.delete();
    m_hold = 1'b0;
    m_rdy  = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("post-release in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    model_step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every downstream handshake consumes one expected group.
  always @(negedge clk) begin
    grp_t x;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb unexpected group actual=out_valid required=none at %0t", $time);
      end else begin
        x = sb_q.pop_front();
        check_group("sb", x);
      end
    end
  end

  initial begin
    logic [7:0] v;
    m_hold = 1'b0;
    m_rdy  = 1'b0;
    do_reset();

    // Eight back-to-back words 0x11..0x88 with downstream always ready.
    for (int i = 0; i < 8; i++) begin
      v = 8'(8'h11 * (i + 1));
      cycle(1'b1, v, 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Three words then a flush on its own.
    cycle(1'b1, 8'h7F, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush together with the fifth word.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    cycle(1'b1, 8'h09, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush on an empty group is ignored.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Full group held under backpressure while inputs keep toggling.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      v = (i % 2 == 0) ? 8'hA5 : 8'h5A;
      cycle(1'b1, v, 1'($urandom_range(0, 1)), 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle after four words.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    #2;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    chk("sb drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
